// File: rtl/leapfrog_scoreboard.sv
// Hit-under-miss controller: in-order miss queue plus the per-cycle decision
// whether the EX instruction may leap past outstanding data-cache misses.
module leapfrog_scoreboard #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned LEAP_LIMIT     = 8,
  parameter bit          MEM_UNDER_MISS = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            miss_valid,
  input  logic                            miss_is_load,
  input  logic [4:0]                      miss_rd,
  output logic                            miss_ready,
  input  logic                            resp_valid,
  output logic                            retire_valid,
  output logic [4:0]                      retire_rd,
  output logic                            retire_is_load,
  input  logic                            cand_valid,
  input  logic [31:0]                     cand_instr,
  input  logic [6:0]                      cand_opcode,
  output logic                            leap,
  output logic                            stall,
  output logic [$clog2(DEPTH+1)-1:0]      pending_count,
  output logic [$clog2(LEAP_LIMIT+1)-1:0] leap_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned LW = $clog2(LEAP_LIMIT + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic       is_load;
    logic [4:0] rd;
  } entry_t;

  entry_t           entries [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  logic       do_pop;
  logic       do_alloc;
  logic       pending;
  logic       use_rs1;
  logic       use_rs2;
  logic       has_rd;
  logic       is_mem;
  logic       hazard;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign rs1 = cand_instr[19:15];
  assign rs2 = cand_instr[24:20];
  assign rd  = cand_instr[11:7];

  // A full queue still accepts a miss in the same cycle its head pops.
  assign miss_ready = (pending_count != CW'(DEPTH));
  assign do_pop     = resp_valid & (pending_count != '0);
  assign do_alloc   = miss_valid & (miss_ready | do_pop);
  assign pending    = (pending_count != '0) | miss_valid;

  // Operand usage by opcode class.
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b1;
    has_rd  = 1'b1;
    is_mem  = 1'b0;
    case (cand_opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
      OP_JALR, OP_IMM, OP_CSR: begin
        use_rs2 = 1'b0;
      end
      OP_LOAD: begin
        use_rs2 = 1'b0;
        is_mem  = 1'b1;
      end
      OP_STORE: begin
        has_rd = 1'b0;
        is_mem = 1'b1;
      end
      OP_BRANCH: begin
        has_rd = 1'b0;
      end
      default: begin
        use_rs2 = 1'b1;
      end
    endcase
  end

  function automatic logic rd_hit(input logic [4:0] h, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic [4:0] d,
                                  input logic u1, input logic u2, input logic ud);
    return (h != 5'd0) && ((u1 && (h == s1)) || (u2 && (h == s2)) || (ud && (h == d)));
  endfunction

  // RAW/WAW against every tracked load, including one popping this cycle.
  always_comb begin
    hazard = 1'b0;
    if (miss_valid && miss_is_load &&
        rd_hit(miss_rd, rs1, rs2, rd, use_rs1, use_rs2, has_rd)) begin
      hazard = 1'b1;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entry_valid[i] && entries[i].is_load &&
          rd_hit(entries[i].rd, rs1, rs2, rd, use_rs1, use_rs2, has_rd)) begin
        hazard = 1'b1;
      end
    end
  end

  assign leap = cand_valid & pending & (cand_instr != NOP_INSTR) & ~hazard &
                (~is_mem | (MEM_UNDER_MISS & miss_ready)) &
                (leap_count < LW'(LEAP_LIMIT));
  assign stall = cand_valid & pending & ~leap;

  always_ff @(posedge clk) begin
    if (do_alloc) begin
      entries[tail] <= '{is_load: miss_is_load, rd: miss_is_load ? miss_rd : 5'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head           <= '0;
      tail           <= '0;
      entry_valid    <= '0;
      pending_count  <= '0;
      leap_count     <= '0;
      retire_valid   <= 1'b0;
      retire_rd      <= 5'd0;
      retire_is_load <= 1'b0;
    end else begin
      retire_valid <= do_pop;
      if (do_pop) begin
        head              <= head + PW'(1);
        entry_valid[head] <= 1'b0;
        retire_rd         <= entries[head].rd;
        retire_is_load    <= entries[head].is_load;
      end
      if (do_alloc) begin
        tail              <= tail + PW'(1);
        entry_valid[tail] <= 1'b1;
      end
      if (do_alloc && !do_pop) begin
        pending_count <= pending_count + CW'(1);
      end else if (do_pop && !do_alloc) begin
        pending_count <= pending_count - CW'(1);
      end
      // Epoch ends when the last miss drains with nothing new arriving.
      if (do_pop && !do_alloc && (pending_count == CW'(1))) begin
        leap_count <= '0;
      end else if (leap) begin
        leap_count <= leap_count + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_leapfrog_scoreboard.sv
// Directed bench for leapfrog_scoreboard: two instances (memory ops allowed /
// blocked under a miss) share stimulus; retires are checked against a queue.
module tb_leapfrog_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic        miss_is_load;
  logic [4:0]  miss_rd;
  logic        resp_valid;
  logic        cand_valid;
  logic [31:0] cand_instr;
  logic [6:0]  cand_opcode;

  logic        miss_ready, retire_valid, retire_is_load, leap, stall;
  logic [4:0]  retire_rd;
  logic [2:0]  pending_count;
  logic [3:0]  leap_count;

  logic        m0_ready, r0_valid, r0_is_load, leap0, stall0;
  logic [4:0]  r0_rd;
  logic [2:0]  pc0;
  logic [3:0]  lc0;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] model_q[$];
  logic [5:0] exp_q[$];
  logic [5:0] e;

  always #5 clk = ~clk;

  leapfrog_scoreboard #(.DEPTH(4), .LEAP_LIMIT(8), .MEM_UNDER_MISS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_is_load(miss_is_load),
    .miss_rd(miss_rd), .miss_ready(miss_ready), .resp_valid(resp_valid),
    .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_is_load(retire_is_load),
    .cand_valid(cand_valid), .cand_instr(cand_instr), .cand_opcode(cand_opcode),
    .leap(leap), .stall(stall), .pending_count(pending_count), .leap_count(leap_count)
  );

  leapfrog_scoreboard #(.DEPTH(4), .LEAP_LIMIT(8), .MEM_UNDER_MISS(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_is_load(miss_is_load),
    .miss_rd(miss_rd), .miss_ready(m0_ready), .resp_valid(resp_valid),
    .retire_valid(r0_valid), .retire_rd(r0_rd), .retire_is_load(r0_is_load),
    .cand_valid(cand_valid), .cand_instr(cand_instr), .cand_opcode(cand_opcode),
    .leap(leap0), .stall(stall0), .pending_count(pc0), .leap_count(lc0)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Same expectation for both instances.
  task automatic chk_ls(input string name, input int l, input int s);
    chk({name, "_leap"}, int'(leap), l);
    chk({name, "_stall"}, int'(stall), s);
    chk({name, "_leap0"}, int'(leap0), l);
    chk({name, "_stall0"}, int'(stall0), s);
  endtask

  task automatic chk_cnt(input string name, input int pc, input int lc);
    chk({name, "_pending"}, int'(pending_count), pc);
    chk({name, "_leapcnt"}, int'(leap_count), lc);
    chk({name, "_pending0"}, int'(pc0), pc);
    chk({name, "_leapcnt0"}, int'(lc0), lc);
  endtask

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_op(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'd0, rd, op};
  endfunction

  task automatic step(input logic mv, input logic ml, input logic [4:0] mrd,
                      input logic rv, input logic cv, input logic [31:0] instr);
    miss_valid   = mv;
    miss_is_load = ml;
    miss_rd      = mrd;
    resp_valid   = rv;
    cand_valid   = cv;
    cand_instr   = instr;
    cand_opcode  = instr[6:0];
    #1;
  endtask

  // Reference queue: records expected retires, then advances one clock.
  task automatic tick();
    logic pop;
    logic full;
    if (!rst) begin
      model_q.delete();
    end else begin
      full = (model_q.size() == 4);
      pop  = resp_valid && (model_q.size() != 0);
      if (pop) exp_q.push_back(model_q.pop_front());
      if (miss_valid && (!full || pop))
        model_q.push_back({miss_is_load, miss_is_load ? miss_rd : 5'd0});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (retire_valid || r0_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_retire: got rd=%0d load=%0d expected no retire",
                 retire_rd, retire_is_load);
      end else begin
        e = exp_q.pop_front();
        chk("retire_both_valid", int'({retire_valid, r0_valid}), 3);
        chk("retire_rd", int'(retire_rd), int'(e[4:0]));
        chk("retire_is_load", int'(retire_is_load), int'(e[5]));
        chk("retire_rd0", int'(r0_rd), int'(e[4:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] add_776, addi_95, sub_431, lui_3, lw_20, add_22;
    add_776 = r_op(7'd0, 5'd7, 5'd6, 5'd8);
    addi_95 = i_op(7'b0010011, 5'd9, 5'd5, 12'd4);
    sub_431 = r_op(7'b0100000, 5'd4, 5'd3, 5'd1);
    lui_3   = {20'd1, 5'd3, 7'b0110111};
    lw_20   = i_op(7'b0000011, 5'd20, 5'd21, 12'd0);
    add_22  = r_op(7'd0, 5'd22, 5'd23, 5'd24);

    rst = 1'b0;
    step(0, 0, 0, 0, 0, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 32'h0);
    chk_cnt("reset", 0, 0);
    chk("reset_retire", int'(retire_valid), 0);
    chk("reset_ready", int'(miss_ready), 1);
    chk_ls("reset", 0, 0);
    tick();

    // Independent ALU op leaps the allocating load miss.
    step(1, 1, 5'd5, 0, 1, add_776);
    chk_ls("t1", 1, 0);
    tick();
    step(0, 0, 0, 0, 1, addi_95);
    chk_cnt("t1_after", 1, 1);
    chk_ls("t2_raw", 0, 1);
    tick();
    step(0, 0, 0, 1, 1, addi_95);
    chk_ls("t2_popping", 0, 1);
    tick();
    step(0, 0, 0, 0, 1, addi_95);
    chk_cnt("t2_drained", 0, 0);
    chk_ls("t2_idle", 0, 0);
    tick();

    // Forwarded hazard from the same-cycle miss, then WAW on the entry.
    step(1, 1, 5'd3, 0, 1, sub_431);
    chk_ls("t3_fwd", 0, 1);
    tick();
    step(0, 0, 0, 0, 1, lui_3);
    chk_ls("t3_waw", 0, 1);
    chk_cnt("t3", 1, 0);
    tick();
    step(0, 0, 0, 1, 0, 32'h0);
    chk_ls("t3_nocand", 0, 0);
    tick();

    // Fill the queue; fifth miss is dropped.
    step(1, 1, 5'd10, 0, 0, 32'h0);
    chk("f1_ready", int'(miss_ready), 1);
    tick();
    step(1, 1, 5'd11, 0, 0, 32'h0);
    tick();
    step(1, 1, 5'd12, 0, 0, 32'h0);
    tick();
    step(1, 0, 5'd13, 0, 0, 32'h0);
    chk("f4_ready", int'(miss_ready), 1);
    chk_cnt("f4", 3, 0);
    tick();
    step(1, 1, 5'd14, 0, 0, 32'h0);
    chk("f5_ready", int'(miss_ready), 0);
    chk_cnt("f5", 4, 0);
    tick();
    step(0, 0, 0, 0, 1, lw_20);
    chk_cnt("f6_full", 4, 0);
    chk_ls("f6_mem_full", 0, 1);
    tick();
    step(1, 1, 5'd15, 1, 1, add_22);
    chk("f7_ready", int'(miss_ready), 0);
    chk_ls("f7_alu", 1, 0);
    tick();
    step(0, 0, 0, 1, 0, 32'h0);
    chk_cnt("f8_wrapped", 4, 1);
    tick();
    step(0, 0, 0, 1, 0, 32'h0);
    chk_cnt("f9", 3, 1);
    tick();
    step(0, 0, 0, 1, 0, 32'h0);
    tick();
    step(0, 0, 0, 1, 0, 32'h0);
    chk_cnt("f11", 1, 1);
    tick();
    step(0, 0, 0, 0, 0, 32'h0);
    chk_cnt("f12_drained", 0, 0);
    tick();

    // Leap budget: eight leaps, then stall until drain.
    step(1, 1, 5'd5, 0, 0, 32'h0);
    tick();
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0, 1, add_776);
      chk($sformatf("lim%0d_leapcnt", i), int'(leap_count), i);
      chk_ls($sformatf("lim%0d", i), (i < 8) ? 1 : 0, (i < 8) ? 0 : 1);
      tick();
    end
    step(0, 0, 0, 1, 1, add_776);
    chk_cnt("lim_sat", 1, 8);
    chk_ls("lim_sat", 0, 1);
    tick();
    step(0, 0, 0, 0, 0, 32'h0);
    chk_cnt("lim_drained", 0, 0);
    tick();

    // Memory op under a store miss: allowed on one instance only.
    step(1, 0, 5'd9, 0, 0, 32'h0);
    tick();
    step(0, 0, 0, 0, 1, lw_20);
    chk("m2_leap", int'(leap), 1);
    chk("m2_stall", int'(stall), 0);
    chk("m2_leap0", int'(leap0), 0);
    chk("m2_stall0", int'(stall0), 1);
    tick();
    step(1, 1, 5'd6, 0, 0, 32'h0);
    chk("m3_leapcnt", int'(leap_count), 1);
    chk("m3_leapcnt0", int'(lc0), 0);
    chk("m3_pending", int'(pending_count), 1);
    tick();

    // Reset with two entries queued: no retires survive.
    rst = 1'b0;
    step(0, 0, 0, 1, 0, 32'h0);
    tick();
    rst = 1'b1;
    step(0, 0, 0, 1, 0, 32'h0);
    chk_cnt("m5_reset", 0, 0);
    chk("m5_retire", int'(retire_valid), 0);
    tick();
    step(0, 0, 0, 0, 0, 32'h0);
    chk_cnt("m6_empty_resp", 0, 0);
    chk("m6_retire", int'(retire_valid), 0);
    tick();
    tick();

    chk("retire_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/leapfrog_scoreboard.md
Name: leapfrog_scoreboard

Overview:
- Multi-entry hit-under-miss controller for the RV32I pipeline.
- Tracks up to DEPTH outstanding data-cache misses (loads and stores) in an in-order miss queue.
- Each cycle, decides whether the instruction in EX may proceed ("leap") past the pending misses, or must stall.
- Sits between the MA stage, the data-cache response path and the pipeline stall logic; replaces the single-miss leap check.

Parameters:
- DEPTH, 4, number of miss-queue entries (power of 2, ≥2).
- LEAP_LIMIT, 8, maximum instructions leaped per drain epoch before a forced stall.
- MEM_UNDER_MISS, 0, 1 lets an independent load/store leap (and allocate) under a miss; 0 blocks all memory ops while any miss is pending.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- miss_valid  in  1  MA-stage load/store missed this cycle; allocate an entry.
- miss_is_load  in  1  1 = load (rd tracked), 0 = store.
- miss_rd  in  5  destination register of the missing load.
- miss_ready  out  1  queue can accept an allocation this cycle.
- resp_valid  in  1  cache completed the oldest miss; pop the head.
- retire_valid  out  1  registered; head popped last cycle.
- retire_rd  out  5  rd of the popped entry (0 for stores).
- retire_is_load  out  1  type of the popped entry.
- cand_valid  in  1  EX holds a valid instruction.
- cand_instr  in  32  EX instruction word.
- cand_opcode  in  7  EX opcode (rv32i_opcode encoding).
- leap  out  1  combinational; EX instruction may advance while misses are pending.
- stall  out  1  combinational; cand_valid & pending & !leap.
- pending_count  out  $clog2(DEPTH+1)  occupied entries.
- leap_count  out  $clog2(LEAP_LIMIT+1)  leaps granted in the current epoch.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Queue emptied; head/tail pointers reset to 0.
  - pending_count=0, leap_count=0, retire_valid=0, retire_rd=0, retire_is_load=0.
  - Reset mid-operation discards all entries; no retire is issued for them.
- Queue:
  - Circular FIFO of {is_load, rd}.
  - miss_ready = (pending_count != DEPTH).
  - Allocate on miss_valid & miss_ready; miss_valid while full is ignored (no state change).
  - Pop on resp_valid & (pending_count != 0); resp_valid while empty is ignored.
  - Simultaneous allocate and pop: count unchanged; both pointers advance; legal when full.
  - Pointers wrap modulo DEPTH.
- Retire: cycle after a pop, retire_valid=1 for one cycle with the head's rd and is_load; otherwise retire_valid=0.
- pending: (pending_count != 0) | miss_valid. The allocating MA miss counts as pending in the same cycle.
- Source decode from cand_instr:
  - lui, auipc, jal: no sources.
  - jalr, load, imm, csr: rs1=[19:15].
  - others: rs1=[19:15], rs2=[24:20].
  - Register x0 never matches.
- Hazard set: every valid entry with is_load=1, plus the incoming miss if miss_valid & miss_is_load.
  - An entry being popped this cycle is still in the set (conservative).
- leap=1 iff all of the following hold:
  - cand_valid and pending.
  - cand_instr != 32'h00000013.
  - No candidate source matches any hazard rd.
  - Candidate rd=[11:7] matches no hazard rd (WAW), unless the candidate has no rd (branch, store).
  - If the candidate is a load/store: MEM_UNDER_MISS=1 and miss_ready.
  - leap_count < LEAP_LIMIT.
- When nothing is pending, leap=0 and stall=0 (normal flow).
- leap_count:
  - Increments on each leap=1 cycle, saturating at LEAP_LIMIT.
  - Cleared to 0 on the cycle pending_count transitions to 0 with no concurrent allocation.
  - At LEAP_LIMIT, stall holds until the queue drains.

Test Plan:
- Load miss rd=x5 allocated; EX "add x7,x6,x8" → leap=1, pending_count=1, leap_count=1 next cycle.
- Load miss rd=x5 pending; EX "addi x9,x5,4" → leap=0, stall=1; after resp_valid, retire_valid=1 with retire_rd=5, pending_count=0, stall=0.
- Same-cycle miss_valid (load rd=x3) with EX "sub x4,x3,x1" → leap=0 (forwarded hazard); EX "lui x3,1" → leap=0 (WAW).
- DEPTH=4: five back-to-back misses with MEM_UNDER_MISS=1 → miss_ready=0 after the fourth; fifth ignored; simultaneous alloc+resp while full keeps count=4 and wraps the pointers.
- LEAP_LIMIT=8: nine independent ALU ops under one pending miss → leap=1 for the first eight, stall on the ninth; leap_count=8 until drain, then 0.
- MEM_UNDER_MISS=0: store miss pending, EX load with no dependency → leap=0. Assert rst=0 mid-queue → pending_count=0 and no retire_valid next cycle.
